// File: rtl/atmega_tim_pkg.sv
// Shared register bit positions and clock-select encodings for the AVR-style
// 8-bit timer with input capture.
package atmega_tim_pkg;

  localparam int unsigned TCCR_CS_LSB   = 0;
  localparam int unsigned TCCR_CS_MSB   = 2;
  localparam int unsigned TCCR_ICES_BIT = 6;
  localparam int unsigned TCCR_ICNC_BIT = 7;
  localparam int unsigned TIMSK_TOIE_BIT = 0;
  localparam int unsigned TIMSK_ICIE_BIT = 5;
  localparam int unsigned TIFR_TOV_BIT   = 0;
  localparam int unsigned TIFR_ICF_BIT   = 5;

  typedef enum logic [2:0] {
    CS_STOP    = 3'b000,
    CS_CLK1    = 3'b001,
    CS_CLK8    = 3'b010,
    CS_CLK64   = 3'b011,
    CS_CLK256  = 3'b100,
    CS_CLK1024 = 3'b101,
    CS_RSV6    = 3'b110,
    CS_RSV7    = 3'b111
  } cs_e;

  // pre_rise is {clk1024, clk256, clk64, clk8} rising-edge pulses.
  function automatic logic cs_tick(input cs_e cs, input logic [3:0] pre_rise);
    logic t;
    t = 1'b0;
    case (cs)
      CS_CLK1:    t = 1'b1;
      CS_CLK8:    t = pre_rise[0];
      CS_CLK64:   t = pre_rise[1];
      CS_CLK256:  t = pre_rise[2];
      CS_CLK1024: t = pre_rise[3];
      CS_STOP:    t = 1'b0;
      CS_RSV6:    t = 1'b0;
      CS_RSV7:    t = 1'b0;
      default:    t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/atmega_icp_filter.sv
// Capture-pin conditioning: 2-flop synchronizer, optional noise canceller
// (ATMEGA_TIM_CAPTURE_NOISE_CANCEL_EN) and rise/fall edge detector.
module atmega_icp_filter (
  input  logic clk_i,
  input  logic rst_i,
  input  logic icp_i,
`ifdef ATMEGA_TIM_CAPTURE_NOISE_CANCEL_EN
  input  logic icnc_i,
`endif
  output logic rise_o,
  output logic fall_o
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic level_s;

  // synchronizer for the asynchronous pin
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= icp_i;
      sync2_r <= sync1_r;
    end
  end

`ifdef ATMEGA_TIM_CAPTURE_NOISE_CANCEL_EN
  logic       filt_r;
  logic [2:0] run_r;

  // level follows the synchronized pin only after four equal differing samples;
  // while bypassed it tracks the pin so enabling it causes no spurious edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_r <= 1'b0;
      run_r  <= 3'd0;
    end else if (!icnc_i) begin
      filt_r <= sync2_r;
      run_r  <= 3'd0;
    end else if (sync2_r == filt_r) begin
      run_r  <= 3'd0;
    end else if (run_r == 3'd3) begin
      filt_r <= sync2_r;
      run_r  <= 3'd0;
    end else begin
      run_r  <= run_r + 3'd1;
    end
  end

  assign level_s = icnc_i ? filt_r : sync2_r;
`else
  assign level_s = sync2_r;
`endif

  // edge-history flop for the filtered level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level_s;
    end
  end

  assign rise_o = level_s & ~prev_r;
  assign fall_o = ~level_s & prev_r;

endmodule

// File: rtl/atmega_tim_capture.sv
// 8-bit timer/counter with input capture unit and overflow/capture interrupts.
// Optional noise canceller enabled by `define ATMEGA_TIM_CAPTURE_NOISE_CANCEL_EN.
module atmega_tim_capture
  import atmega_tim_pkg::*;
#(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCCR_ADDR  = 8'h80,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCNT_ADDR  = 8'h81,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] ICR_ADDR   = 8'h82,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TIMSK_ADDR = 8'h6F,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TIFR_ADDR  = 8'h36
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clk8_i,
  input  logic                         clk64_i,
  input  logic                         clk256_i,
  input  logic                         clk1024_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  input  logic                         icp_i,
  output logic                         icp_int_o,
  output logic                         tov_int_o,
  input  logic                         icp_int_ack_i,
  input  logic                         tov_int_ack_i
);

  logic [2:0] cs_r;
  logic       ices_r;
  logic       icnc_s;
  logic [7:0] tcnt_r;
  logic [7:0] icr_r;
  logic       toie_r;
  logic       icie_r;
  logic       tov_r;
  logic       icf_r;
  logic [3:0] pre_prev_r;

  logic       wr_tccr_s;
  logic       wr_tcnt_s;
  logic       wr_timsk_s;
  logic       wr_tifr_s;
  logic [3:0] pre_rise_s;
  logic       tick_s;
  logic       wrap_s;
  logic       rise_s;
  logic       fall_s;
  logic       cap_s;
  logic       clr_tov_s;
  logic       clr_icf_s;
  logic [7:0] tccr_view_s;
  logic [7:0] timsk_view_s;
  logic [7:0] tifr_view_s;

  assign wr_tccr_s  = wr_i && (addr_i == TCCR_ADDR);
  assign wr_tcnt_s  = wr_i && (addr_i == TCNT_ADDR);
  assign wr_timsk_s = wr_i && (addr_i == TIMSK_ADDR);
  assign wr_tifr_s  = wr_i && (addr_i == TIFR_ADDR);

  assign pre_rise_s = {clk1024_i, clk256_i, clk64_i, clk8_i} & ~pre_prev_r;
  assign tick_s     = cs_tick(cs_e'(cs_r), pre_rise_s);
  assign wrap_s     = tick_s && !wr_tcnt_s && (tcnt_r == 8'hFF);
  assign cap_s      = ices_r ? rise_s : fall_s;
  assign clr_tov_s  = (wr_tifr_s && bus_i[TIFR_TOV_BIT]) || tov_int_ack_i;
  assign clr_icf_s  = (wr_tifr_s && bus_i[TIFR_ICF_BIT]) || icp_int_ack_i;

  atmega_icp_filter u_filter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .icp_i  (icp_i),
`ifdef ATMEGA_TIM_CAPTURE_NOISE_CANCEL_EN
    .icnc_i (icnc_s),
`endif
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

`ifdef ATMEGA_TIM_CAPTURE_NOISE_CANCEL_EN
  logic icnc_r;

  // noise-canceller enable bit exists only in the filtered build
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      icnc_r <= 1'b0;
    end else if (wr_tccr_s) begin
      icnc_r <= bus_i[TCCR_ICNC_BIT];
    end else begin
      icnc_r <= icnc_r;
    end
  end

  assign icnc_s = icnc_r;
`else
  assign icnc_s = 1'b0;
`endif

  // control and mask registers plus prescaler edge history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_r       <= 3'd0;
      ices_r     <= 1'b0;
      toie_r     <= 1'b0;
      icie_r     <= 1'b0;
      pre_prev_r <= 4'd0;
    end else begin
      pre_prev_r <= {clk1024_i, clk256_i, clk64_i, clk8_i};
      if (wr_tccr_s) begin
        cs_r   <= bus_i[TCCR_CS_MSB:TCCR_CS_LSB];
        ices_r <= bus_i[TCCR_ICES_BIT];
      end
      if (wr_timsk_s) begin
        toie_r <= bus_i[TIMSK_TOIE_BIT];
        icie_r <= bus_i[TIMSK_ICIE_BIT];
      end
    end
  end

  // counter, capture register and flags; a bus write to TCNT beats a tick,
  // and flag set events beat same-cycle clears
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcnt_r <= 8'h00;
      icr_r  <= 8'h00;
      tov_r  <= 1'b0;
      icf_r  <= 1'b0;
    end else begin
      if (wr_tcnt_s) begin
        tcnt_r <= bus_i;
      end else if (tick_s) begin
        tcnt_r <= tcnt_r + 8'd1;
      end
      if (cap_s) begin
        icr_r <= tcnt_r;
      end
      if (wrap_s) begin
        tov_r <= 1'b1;
      end else if (clr_tov_s) begin
        tov_r <= 1'b0;
      end
      if (cap_s) begin
        icf_r <= 1'b1;
      end else if (clr_icf_s) begin
        icf_r <= 1'b0;
      end
    end
  end

  // register views with unimplemented bits reading zero
  always_comb begin
    tccr_view_s  = 8'h00;
    timsk_view_s = 8'h00;
    tifr_view_s  = 8'h00;
    tccr_view_s[TCCR_CS_MSB:TCCR_CS_LSB] = cs_r;
    tccr_view_s[TCCR_ICES_BIT]  = ices_r;
    tccr_view_s[TCCR_ICNC_BIT]  = icnc_s;
    timsk_view_s[TIMSK_TOIE_BIT] = toie_r;
    timsk_view_s[TIMSK_ICIE_BIT] = icie_r;
    tifr_view_s[TIFR_TOV_BIT]    = tov_r;
    tifr_view_s[TIFR_ICF_BIT]    = icf_r;
  end

  always_comb begin
    bus_o = 8'h00;
    if (rd_i) begin
      if (addr_i == TCCR_ADDR) begin
        bus_o = tccr_view_s;
      end else if (addr_i == TCNT_ADDR) begin
        bus_o = tcnt_r;
      end else if (addr_i == ICR_ADDR) begin
        bus_o = icr_r;
      end else if (addr_i == TIMSK_ADDR) begin
        bus_o = timsk_view_s;
      end else if (addr_i == TIFR_ADDR) begin
        bus_o = tifr_view_s;
      end else begin
        bus_o = 8'h00;
      end
    end else begin
      bus_o = 8'h00;
    end
  end

  assign icp_int_o = icf_r & icie_r;
  assign tov_int_o = tov_r & toie_r;

endmodule

// File: tb/tb_atmega_tim_capture.sv
// Self-checking bench for atmega_tim_capture: directed scenarios plus a
// randomized phase, all checked against a cycle-level behavioural model.
module tb_atmega_tim_capture;

  localparam logic [7:0] A_TCCR  = 8'h80;
  localparam logic [7:0] A_TCNT  = 8'h81;
  localparam logic [7:0] A_ICR   = 8'h82;
  localparam logic [7:0] A_TIMSK = 8'h6F;
  localparam logic [7:0] A_TIFR  = 8'h36;

  logic       clk = 1'b0;
  logic       rst;
  logic       c8, c64, c256, c1024;
  logic [7:0] addr;
  logic       wr, rd;
  logic [7:0] bus_w;
  logic [7:0] bus_r;
  logic       icp;
  logic       icp_int, tov_int;
  logic       icp_ack, tov_ack;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  logic [7:0] m_tcnt, m_icr;
  logic [2:0] m_cs;
  logic       m_ices, m_toie, m_icie, m_tov, m_icf;
  logic       h1, h2, h3;
  logic [3:0] m_pprev;

  always #5 clk = ~clk;

  atmega_tim_capture dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clk8_i        (c8),
    .clk64_i       (c64),
    .clk256_i      (c256),
    .clk1024_i     (c1024),
    .addr_i        (addr),
    .wr_i          (wr),
    .rd_i          (rd),
    .bus_i         (bus_w),
    .bus_o         (bus_r),
    .icp_i         (icp),
    .icp_int_o     (icp_int),
    .tov_int_o     (tov_int),
    .icp_int_ack_i (icp_ack),
    .tov_int_ack_i (tov_ack)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      A_TCCR:  return {1'b0, m_ices, 3'b000, m_cs};
      A_TCNT:  return m_tcnt;
      A_ICR:   return m_icr;
      A_TIMSK: return {2'b00, m_icie, 4'b0000, m_toie};
      A_TIFR:  return {2'b00, m_icf, 4'b0000, m_tov};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_tcnt = 8'h00; m_icr = 8'h00; m_cs = 3'd0; m_ices = 1'b0;
    m_toie = 1'b0; m_icie = 1'b0; m_tov = 1'b0; m_icf = 1'b0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; m_pprev = 4'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a);
    addr = a; rd = 1'b1;
    #1;
    chk(tag, bus_r, m_read(a));
    rd = 1'b0;
  endtask

  task automatic rd_val(input logic [7:0] a, output logic [7:0] v);
    addr = a; rd = 1'b1;
    #1;
    v = bus_r;
    rd = 1'b0;
  endtask

  // One clock: model predicts the effect of the current inputs, then the DUT clocks.
  task automatic step();
    logic       tickv, wr_cnt, cap, clr_tov, clr_icf, wrap;
    logic [3:0] pr;
    pr = {c1024, c256, c64, c8} & ~m_pprev;
    case (m_cs)
      3'd1:    tickv = 1'b1;
      3'd2:    tickv = pr[0];
      3'd3:    tickv = pr[1];
      3'd4:    tickv = pr[2];
      3'd5:    tickv = pr[3];
      default: tickv = 1'b0;
    endcase
    wr_cnt  = wr && (addr == A_TCNT);
    // pin level seen by the edge detector lags the pin by two samples
    cap     = m_ices ? (h2 && !h3) : (!h2 && h3);
    clr_tov = (wr && addr == A_TIFR && bus_w[0]) || tov_ack;
    clr_icf = (wr && addr == A_TIFR && bus_w[5]) || icp_ack;
    wrap    = tickv && !wr_cnt && (m_tcnt == 8'hFF);
    if (cap) m_icr = m_tcnt;
    m_icf  = cap  ? 1'b1 : (clr_icf ? 1'b0 : m_icf);
    m_tov  = wrap ? 1'b1 : (clr_tov ? 1'b0 : m_tov);
    m_tcnt = wr_cnt ? bus_w : (tickv ? m_tcnt + 8'd1 : m_tcnt);
    if (wr && addr == A_TCCR) begin
      m_cs = bus_w[2:0]; m_ices = bus_w[6];
    end
    if (wr && addr == A_TIMSK) begin
      m_toie = bus_w[0]; m_icie = bus_w[5];
    end
    h3 = h2; h2 = h1; h1 = icp;
    m_pprev = {c1024, c256, c64, c8};
    @(posedge clk);
    #1;
    wr = 1'b0; icp_ack = 1'b0; tov_ack = 1'b0;
    chk("tov_int", {7'd0, tov_int}, {7'd0, m_tov & m_toie});
    chk("icp_int", {7'd0, icp_int}, {7'd0, m_icf & m_icie});
  endtask

  task automatic wr_step(input logic [7:0] a, input logic [7:0] d);
    addr = a; bus_w = d; wr = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] ra;
    int r;
    rst = 1'b1; c8 = 1'b0; c64 = 1'b0; c256 = 1'b0; c1024 = 1'b0;
    addr = 8'h00; wr = 1'b0; rd = 1'b0; bus_w = 8'h00; icp = 1'b0;
    icp_ack = 1'b0; tov_ack = 1'b0;
    model_reset();

    // reset state
    #2;
    rd_chk("rst_tccr", A_TCCR);
    rd_chk("rst_tcnt", A_TCNT);
    rd_chk("rst_tifr", A_TIFR);
    chk("rst_ints", {6'd0, icp_int, tov_int}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // overflow: FE -> FF -> 00 with TOV and tov_int, then ack
    wr_step(A_TIMSK, 8'h01);
    wr_step(A_TCCR, 8'h01);
    wr_step(A_TCNT, 8'hFE);
    rd_val(A_TCNT, v); chk("ovf_tcnt_fe", v, 8'hFE);
    step();
    rd_val(A_TCNT, v); chk("ovf_tcnt_ff", v, 8'hFF);
    chk("ovf_no_int_yet", {7'd0, tov_int}, 8'h00);
    step();
    rd_val(A_TCNT, v); chk("ovf_tcnt_00", v, 8'h00);
    chk("ovf_int", {7'd0, tov_int}, 8'h01);
    rd_val(A_TIFR, v); chk("ovf_tov", v, 8'h01);
    tov_ack = 1'b1; step();
    rd_val(A_TIFR, v); chk("ovf_ack", v, 8'h00);

    // rising capture: ICES=1, TCNT reaches 10 at sync, ICR=10 three cycles later
    wr_step(A_TCCR, 8'h41);
    wr_step(A_TIMSK, 8'h21);
    wr_step(A_TCNT, 8'h0E);
    icp = 1'b1;
    step(); step();
    chk("cap_not_yet", {7'd0, icp_int}, 8'h00);
    step();
    chk("cap_int", {7'd0, icp_int}, 8'h01);
    rd_val(A_ICR, v); chk("cap_icr", v, 8'h10);
    wr_step(A_ICR, 8'hAA);
    rd_chk("icr_readonly", A_ICR);

    // falling-only capture with overwrite while ICF set
    wr_step(A_TCCR, 8'h01);
    wr_step(A_TIFR, 8'h20);
    icp = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rd_chk("fall_icf", A_TIFR);
    rd_chk("fall_icr", A_ICR);
    icp = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rd_chk("rise_ignored_icr", A_ICR);
    icp = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rd_chk("overwrite_icr", A_ICR);
    rd_val(A_TIFR, v); chk("overwrite_icf", v & 8'h20, 8'h20);

    // write-1 to ICF in the capture cycle leaves ICF set
    wr_step(A_TCCR, 8'h41);
    wr_step(A_TIFR, 8'h20);
    icp = 1'b1;
    step(); step();
    wr_step(A_TIFR, 8'h20);
    rd_val(A_TIFR, v); chk("set_beats_clear", v & 8'h20, 8'h20);

    // TCNT write beats tick and suppresses wrap
    wr_step(A_TIFR, 8'h01);
    wr_step(A_TCNT, 8'hFF);
    wr_step(A_TCNT, 8'h20);
    rd_val(A_TCNT, v); chk("wr_beats_tick", v, 8'h20);
    rd_val(A_TIFR, v); chk("no_wrap_tov", v & 8'h01, 8'h00);

`ifndef ATMEGA_TIM_CAPTURE_NOISE_CANCEL_EN
    wr_step(A_TCCR, 8'hC1);
    rd_val(A_TCCR, v); chk("icnc_reads_0", v, 8'h41);
`endif

    // prescaled counting on clk8 edges
    wr_step(A_TCCR, 8'h02);
    for (int i = 0; i < 12; i++) begin
      c8 = i[0];
      step();
    end
    rd_chk("presc8_tcnt", A_TCNT);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3, 0) == 0) icp = ~icp;
      {c1024, c256, c64, c8} = 4'($urandom);
      icp_ack = ($urandom_range(7, 0) == 0);
      tov_ack = ($urandom_range(7, 0) == 0);
      if ($urandom_range(7, 0) == 0) begin
        r = $urandom_range(4, 0);
        case (r)
          0:       begin addr = A_TCCR;  bus_w = 8'($urandom) & 8'h7F; end
          1:       begin addr = A_TCNT;  bus_w = 8'($urandom); end
          2:       begin addr = A_ICR;   bus_w = 8'($urandom); end
          3:       begin addr = A_TIMSK; bus_w = 8'($urandom); end
          default: begin addr = A_TIFR;  bus_w = 8'($urandom); end
        endcase
        wr = 1'b1;
      end
      step();
      r = $urandom_range(5, 0);
      case (r)
        0:       ra = A_TCCR;
        1:       ra = A_TCNT;
        2:       ra = A_ICR;
        3:       ra = A_TIMSK;
        4:       ra = A_TIFR;
        default: ra = 8'($urandom);
      endcase
      rd_chk("rand_read", ra);
    end

    // reset mid-count with ICF set; pin held high across release
    wr_step(A_TCCR, 8'h41);
    wr_step(A_TIMSK, 8'h21);
    icp = 1'b0;
    for (int i = 0; i < 3; i++) step();
    icp = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rd_val(A_TIFR, v); chk("pre_rst_icf", v & 8'h20, 8'h20);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    rd_chk("async_rst_tcnt", A_TCNT);
    rd_chk("async_rst_tifr", A_TIFR);
    rd_chk("async_rst_icr", A_ICR);
    chk("async_rst_ints", {6'd0, icp_int, tov_int}, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rd_val(A_TIFR, v); chk("no_cap_after_rst", v, 8'h00);

`ifdef ATMEGA_TIM_CAPTURE_NOISE_CANCEL_EN
    // filter enabled, interrupts masked; flags checked directly
    wr_step(A_TCCR, 8'hC0);
    icp = 1'b0;
    for (int i = 0; i < 10; i++) step();
    wr_step(A_TIFR, 8'h20);
    icp = 1'b1; step(); step();
    icp = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rd_val(A_TIFR, v); chk("nc_glitch", v & 8'h20, 8'h00);
    icp = 1'b1;
    for (int i = 0; i < 6; i++) step();
    rd_val(A_TIFR, v); chk("nc_pulse_early", v & 8'h20, 8'h00);
    step();
    rd_val(A_TIFR, v); chk("nc_pulse_cap", v & 8'h20, 8'h20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
